// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU execute stage: opcode and FSM encodings,
// immediate sign extension and NZP derivation.
package alu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_AND  = 3'b001,
        ALU_NOT  = 3'b010,
        ALU_PASS = 3'b011,
        ALU_MUL  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_SRA  = 3'b111
    } aluk_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [WIDTH-1:0] sext5(input logic [4:0] imm);
        return {{(WIDTH-5){imm[4]}}, imm};
    endfunction

    // Returns {N, Z, P}; exactly one bit is set for any value.
    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] result);
        logic n;
        logic z;
        n = result[WIDTH-1];
        z = (result == {WIDTH{1'b0}});
        return {n, z, (!n && !z)};
    endfunction

endpackage

// File: rtl/alu_exec_unit_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
module shift_add_mul #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_nx_s = acc_r;
        if (b_r[cnt_r]) begin
            acc_nx_s = acc_r + (a_r << cnt_r);
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Operand capture, accumulator and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            a_r    <= a;
            b_r    <= b;
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            acc_r  <= acc_nx_s;
            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            busy_r <= (cnt_r != LAST_CNT);
        end else begin
            acc_r  <= acc_r;
            cnt_r  <= cnt_r;
            busy_r <= 1'b0;
        end
    end

    // The final product is the value the last iteration edge would store.
    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == LAST_CNT);
    assign product = acc_nx_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: operand-B select, single-cycle ALU/shift ops, iterative multiply,
// registered writeback result and the NZP condition-code register.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = alu_pkg::WIDTH,
    parameter int MUL_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       ALUK,
    input  logic [WIDTH-1:0] SR1_in,
    input  logic [WIDTH-1:0] SR2_in,
    input  logic [4:0]       Imm5,
    input  logic             SR2MUX,
    input  logic             LD_CC,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             N,
    output logic             Z,
    output logic             P
);

    state_e           state_r;
    state_e           state_nx_s;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_nx_s;
    logic [2:0]       nzp_r;
    logic [2:0]       nzp_nx_s;
    logic             ld_cc_r;
    logic             ld_cc_nx_s;
    logic [WIDTH-1:0] b_s;
    logic [3:0]       sh_s;
    logic [WIDTH-1:0] alu_s;
    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;

    // Operand B select and single-cycle datapath.
    always_comb begin
        b_s   = SR2_in;
        alu_s = {WIDTH{1'b0}};
        if (SR2MUX) begin
            b_s = sext5(Imm5);
        end else begin
            b_s = SR2_in;
        end
        sh_s = b_s[3:0];
        case (aluk_e'(ALUK))
            ALU_ADD:  alu_s = SR1_in + b_s;
            ALU_AND:  alu_s = SR1_in & b_s;
            ALU_NOT:  alu_s = ~SR1_in;
            ALU_PASS: alu_s = SR1_in;
            ALU_SHL:  alu_s = SR1_in << sh_s;
            ALU_SHR:  alu_s = SR1_in >> sh_s;
            ALU_SRA:  alu_s = WIDTH'($signed(SR1_in) >>> sh_s);
            default:  alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state, writeback and condition-code update.
    always_comb begin
        state_nx_s  = state_r;
        result_nx_s = result_r;
        nzp_nx_s    = nzp_r;
        ld_cc_nx_s  = ld_cc_r;
        mul_start_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (Start) begin
                    ld_cc_nx_s = LD_CC;
                    if (aluk_e'(ALUK) == ALU_MUL) begin
                        state_nx_s  = MUL;
                        mul_start_s = 1'b1;
                    end else begin
                        state_nx_s  = DONE;
                        result_nx_s = alu_s;
                        if (LD_CC) begin
                            nzp_nx_s = nzp_of(alu_s);
                        end else begin
                            nzp_nx_s = nzp_r;
                        end
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_nx_s  = DONE;
                    result_nx_s = mul_prod_s;
                    if (ld_cc_r) begin
                        nzp_nx_s = nzp_of(mul_prod_s);
                    end else begin
                        nzp_nx_s = nzp_r;
                    end
                end else begin
                    state_nx_s = MUL;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, result and NZP registers; reset NZP is Z.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            result_r <= {WIDTH{1'b0}};
            nzp_r    <= 3'b010;
            ld_cc_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            result_r <= result_nx_s;
            nzp_r    <= nzp_nx_s;
            ld_cc_r  <= ld_cc_nx_s;
        end
    end

    shift_add_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .start   (mul_start_s),
        .a       (SR1_in),
        .b       (b_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    assign Busy      = (state_r == MUL);
    assign Done      = (state_r == DONE);
    assign Result    = result_r;
    assign {N, Z, P} = nzp_r;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute stage directly downstream of the register file. It consumes the two source-register read values (SR1/SR2) and selects operand B from SR2 or a sign-extended imm5. It computes single-cycle ALU/shift results or a 16-cycle iterative multiply, and presents a registered result for writeback to the register file's Data input. It also owns the NZP condition-code register, loaded from each completed result when requested.

Parameters:
WIDTH, 16, datapath width (all data ports, result, accumulator)
MUL_CYCLES, 16, iterations of the shift-add multiply; must equal WIDTH

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  operation request; sampled only when Busy=0
ALUK  in  3  opcode: 000 ADD, 001 AND, 010 NOT(A), 011 PASS(A), 100 MUL, 101 SHL, 110 SHR logical, 111 SRA
SR1_in  in  WIDTH  operand A, from register-file SR1 read port
SR2_in  in  WIDTH  register operand B, from register-file SR2 read port
Imm5  in  5  immediate, sign-extended to WIDTH
SR2MUX  in  1  1: B=sext(Imm5); 0: B=SR2_in
LD_CC  in  1  update NZP when this operation completes
Busy  out  1  high while a MUL is iterating
Done  out  1  one-cycle completion pulse
Result  out  WIDTH  registered result; held until the next completion
N, Z, P  out  1 each  condition codes

Behaviour:
- Reset (Reset_n=0, asynchronous, any state including mid-MUL): state=IDLE, Busy=0, Done=0, Result=0, N=0, Z=1, P=0. Counter and accumulator clear. An in-flight MUL is discarded with no Done.
- States: IDLE, MUL, DONE. Busy = (state==MUL). Done = (state==DONE).
- Start is accepted in IDLE or DONE, so back-to-back issue is legal. Start is ignored in MUL.
- At the accepting edge, A, B, ALUK and LD_CC are latched. Inputs may change afterwards without effect.
- Single-cycle ops (ALUK != 100): accepting edge writes Result and goes to DONE. Done is high in the next cycle (latency 1).
- MUL: accepting edge goes to MUL with acc=0, cnt=0.
  - On each MUL cycle: if B[cnt], acc += A<<cnt (mod 2^WIDTH); then cnt++.
  - After the MUL_CYCLES-th iteration edge, Result = acc and state goes to DONE.
  - Busy is high for exactly 16 cycles. Done is high in cycle 17 after the accepting edge.
- DONE goes to IDLE after one cycle, unless Start is sampled that cycle, in which case the new op begins.
- Arithmetic:
  - All ops wrap mod 2^WIDTH; no overflow flag.
  - MUL returns the low WIDTH bits of the product (identical for signed and unsigned).
  - Shift amount is B[3:0]; amount 0 leaves the value unchanged. SRA replicates A[15].
- CC update: on the same edge that writes Result, if the latched LD_CC=1, set N=Result[15], Z=(Result==0), P=!N&&!Z. Exactly one of N/Z/P is high at all times. If LD_CC=0, NZP holds.
- Result and NZP never change except at completion or reset.

Decomposition:
- Shared package alu_pkg:
  - aluk_e enum (3-bit, encodings above)
  - state_e enum {IDLE, MUL, DONE}
  - WIDTH default constant
  - function sext5 (5-bit to WIDTH)
  - function nzp_of(result) returning 3 bits
- One natural sub-module: shift_add_mul. It holds acc/cnt, with start/busy/done and a WIDTH-bit product port. The top-level owns operand muxing, single-cycle ops, the FSM and NZP.

Test Plan:
- Reset: hold Reset_n=0, then release → Result=0x0000, NZP=010, Busy=0, Done=0. Assert Reset_n=0 at cycle 5 of a MUL → no Done pulse; outputs return to reset values immediately.
- ADD imm: SR1_in=0x7FFF, SR2MUX=1, Imm5=5'b00001, LD_CC=1, Start for 1 cycle → next cycle Done=1, Result=0x8000, NZP=100. AND with SR2_in=0x0000 → Result=0x0000, NZP=010.
- MUL: A=0x0003, B=0xFFFE (−2), LD_CC=1 → Busy high 16 cycles, Done in cycle 17, Result=0xFFFA, NZP=100. A=0x0100, B=0x0100 → Result=0x0000 (wrap), NZP=010.
- Shifts: A=0x8001, B=0x0004: SHL → 0x0010; SHR → 0x0800; SRA → 0xF800. B=0x0010 (amount 0) → 0x8001.
- Handshake: Start held high through a MUL → ignored while Busy; a second op is accepted on the Done cycle and completes with Done high for exactly one cycle. Changing SR1_in mid-MUL does not affect the result. LD_CC=0 op → NZP unchanged.
